sram_march_seq: RTL



---
 rtl/sram_test_pkg.sv | 67 ++++++
 rtl/sram_march_seq_if.sv | 22 ++
 rtl/march_addr_gen.sv | 36 +++
 rtl/sram_march_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_test_pkg.sv
// Shared definitions for the SRAM March C- sequencer: FSM states and the
// six-element march table (direction, op count, op kind and data polarity).
package sram_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ADV   = 3'd3,
        ST_FIN   = 3'd4
    } march_state_t;

    typedef logic [2:0] elem_idx_t;

    localparam elem_idx_t FIRST_ELEM = 3'd0;
    localparam elem_idx_t LAST_ELEM  = 3'd5;

    // One march element: address direction, whether it has a second op,
    // and for each op whether it writes and whether it uses ~pattern.
    typedef struct packed {
        logic down;
        logic two_ops;
        logic we0;
        logic inv0;
        logic we1;
        logic inv1;
    } march_elem_t;

    function automatic march_elem_t march_elem(input elem_idx_t idx);
        march_elem_t e;
        case (idx)
            3'd0:    e = '{down: 1'b0, two_ops: 1'b0, we0: 1'b1, inv0: 1'b0, we1: 1'b0, inv1: 1'b0};
            3'd1:    e = '{down: 1'b0, two_ops: 1'b1, we0: 1'b0, inv0: 1'b0, we1: 1'b1, inv1: 1'b1};
            3'd2:    e = '{down: 1'b0, two_ops: 1'b1, we0: 1'b0, inv0: 1'b1, we1: 1'b1, inv1: 1'b0};
            3'd3:    e = '{down: 1'b1, two_ops: 1'b1, we0: 1'b0, inv0: 1'b0, we1: 1'b1, inv1: 1'b1};
            3'd4:    e = '{down: 1'b1, two_ops: 1'b1, we0: 1'b0, inv0: 1'b1, we1: 1'b1, inv1: 1'b0};
            3'd5:    e = '{down: 1'b0, two_ops: 1'b0, we0: 1'b0, inv0: 1'b0, we1: 1'b0, inv1: 1'b0};
            default: e = '{down: 1'b0, two_ops: 1'b0, we0: 1'b0, inv0: 1'b0, we1: 1'b0, inv1: 1'b0};
        endcase
        return e;
    endfunction

    function automatic logic elem_down(input elem_idx_t idx);
        march_elem_t e;
        e = march_elem(idx);
        return e.down;
    endfunction

    function automatic logic elem_two_ops(input elem_idx_t idx);
        march_elem_t e;
        e = march_elem(idx);
        return e.two_ops;
    endfunction

    function automatic logic op_we(input elem_idx_t idx, input logic op);
        march_elem_t e;
        e = march_elem(idx);
        return op ? e.we1 : e.we0;
    endfunction

    function automatic logic op_inv(input elem_idx_t idx, input logic op);
        march_elem_t e;
        e = march_elem(idx);
        return op ? e.inv1 : e.inv0;
    endfunction

endpackage

// File: rtl/sram_march_seq_if.sv
// Single-word SRAM controller port driven by the march sequencer.
interface sram_march_seq_if #(
    parameter int AW = 10,
    parameter int DW = 8
);
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_ack;
    logic [DW-1:0] m_rdata;

    modport master (
        output m_req, m_we, m_addr, m_wdata,
        input  m_ack, m_rdata
    );

    modport slave (
        input  m_req, m_we, m_addr, m_wdata,
        output m_ack, m_rdata
    );
endinterface

// File: rtl/march_addr_gen.sv
// Loadable up/down address counter for march elements; 'last' flags the
// final address of the current element's sweep direction.
module march_addr_gen #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic          load_down,
    input  logic          step,
    input  logic          dir_down,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam logic [AW-1:0] ADDR_MIN = {AW{1'b0}};
    localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};
    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] addr_r;

    // address counter: load picks the sweep start, step moves one word
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_r <= ADDR_MIN;
        end else if (load) begin
            addr_r <= load_down ? ADDR_MAX : ADDR_MIN;
        end else if (step) begin
            addr_r <= dir_down ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
        end
    end

    assign addr = addr_r;
    assign last = dir_down ? (addr_r == ADDR_MIN) : (addr_r == ADDR_MAX);

endmodule

// File: rtl/sram_march_seq.sv
// March C- sequencer: sweeps the whole SRAM through the controller port,
// compares each read and reports pass/fail plus first-failure details.
module sram_march_seq
    import sram_test_pkg::*;
#(
    parameter int AW  = 10,
    parameter int DW  = 8,
    parameter int ECW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [DW-1:0]   pattern,
    input  logic            stop_on_fail,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [AW-1:0]   fail_addr,
    output logic [DW-1:0]   fail_exp,
    output logic [DW-1:0]   fail_act,
    output logic [ECW-1:0]  err_cnt,
    sram_march_seq_if.master m
);

    localparam logic [ECW-1:0] ERR_ZERO = {ECW{1'b0}};
    localparam logic [ECW-1:0] ERR_MAX  = {ECW{1'b1}};
    localparam logic [ECW-1:0] ERR_ONE  = {{(ECW-1){1'b0}}, 1'b1};

    march_state_t   state_r, state_n;
    elem_idx_t      elem_r, elem_n_s;
    logic           op_r, op_n_s;
    logic [DW-1:0]  pat_r, pat_sel_s, data_n_s;
    logic           stop_r, mis_r;
    logic           busy_r, done_r, pass_r;
    logic           m_req_r, m_we_r, we_n_s;
    logic [DW-1:0]  m_wdata_r;
    logic [AW-1:0]  fail_addr_r;
    logic [DW-1:0]  fail_exp_r, fail_act_r;
    logic [ECW-1:0] err_cnt_r;

    logic           start_go_s, issue_s, fin_s, step_s, load_s;
    logic           ack_s, rd_mis_s, last_op_s, cur_down_s;
    logic [AW-1:0]  addr_s;
    logic           addr_last_s;

    march_addr_gen #(.AW(AW)) u_addr_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load_s),
        .load_down (elem_down(elem_n_s)),
        .step      (step_s),
        .dir_down  (cur_down_s),
        .addr      (addr_s),
        .last      (addr_last_s)
    );

    assign cur_down_s = elem_down(elem_r);
    assign last_op_s  = !elem_two_ops(elem_r) || op_r;
    assign ack_s      = ((state_r == ST_ISSUE) || (state_r == ST_WAIT)) && m.m_ack;
    // m_wdata_r carries the op's data background, which is also the read expectation
    assign rd_mis_s   = ack_s && !m_we_r && (m.m_rdata != m_wdata_r);
    assign pat_sel_s  = start_go_s ? pattern : pat_r;
    assign we_n_s     = op_we(elem_n_s, op_n_s);
    assign data_n_s   = op_inv(elem_n_s, op_n_s) ? ~pat_sel_s : pat_sel_s;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // next state and march-walk strobes: op first, then address, then element
    always_comb begin
        state_n    = state_r;
        start_go_s = 1'b0;
        issue_s    = 1'b0;
        fin_s      = 1'b0;
        step_s     = 1'b0;
        load_s     = 1'b0;
        elem_n_s   = elem_r;
        op_n_s     = op_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    start_go_s = 1'b1;
                    issue_s    = 1'b1;
                    load_s     = 1'b1;
                    elem_n_s   = FIRST_ELEM;
                    op_n_s     = 1'b0;
                    state_n    = ST_ISSUE;
                end else begin
                    state_n    = ST_IDLE;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (m.m_ack) begin
                    state_n = ST_ADV;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_ADV: begin
                if (stop_r && mis_r) begin
                    fin_s   = 1'b1;
                    state_n = ST_FIN;
                end else if (!last_op_s) begin
                    op_n_s  = 1'b1;
                    issue_s = 1'b1;
                    state_n = ST_ISSUE;
                end else if (!addr_last_s) begin
                    op_n_s  = 1'b0;
                    step_s  = 1'b1;
                    issue_s = 1'b1;
                    state_n = ST_ISSUE;
                end else if (elem_r != LAST_ELEM) begin
                    elem_n_s = elem_r + 3'd1;
                    op_n_s   = 1'b0;
                    load_s   = 1'b1;
                    issue_s  = 1'b1;
                    state_n  = ST_ISSUE;
                end else begin
                    fin_s   = 1'b1;
                    state_n = ST_FIN;
                end
            end
            ST_FIN: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // run control, bus request and result registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            elem_r      <= FIRST_ELEM;
            op_r        <= 1'b0;
            pat_r       <= {DW{1'b0}};
            stop_r      <= 1'b0;
            mis_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            m_req_r     <= 1'b0;
            m_we_r      <= 1'b0;
            m_wdata_r   <= {DW{1'b0}};
            fail_addr_r <= {AW{1'b0}};
            fail_exp_r  <= {DW{1'b0}};
            fail_act_r  <= {DW{1'b0}};
            err_cnt_r   <= ERR_ZERO;
        end else begin
            done_r <= fin_s;
            if (start_go_s) begin
                pat_r       <= pattern;
                stop_r      <= stop_on_fail;
                mis_r       <= 1'b0;
                busy_r      <= 1'b1;
                pass_r      <= 1'b0;
                fail_addr_r <= {AW{1'b0}};
                fail_exp_r  <= {DW{1'b0}};
                fail_act_r  <= {DW{1'b0}};
                err_cnt_r   <= ERR_ZERO;
            end else if (fin_s) begin
                busy_r <= 1'b0;
                pass_r <= (err_cnt_r == ERR_ZERO);
            end
            if (issue_s) begin
                m_req_r   <= 1'b1;
                m_we_r    <= we_n_s;
                m_wdata_r <= data_n_s;
                elem_r    <= elem_n_s;
                op_r      <= op_n_s;
            end else if (ack_s) begin
                m_req_r <= 1'b0;
            end
            if (ack_s) begin
                mis_r <= rd_mis_s;
                if (rd_mis_s) begin
                    if (err_cnt_r != ERR_MAX) begin
                        err_cnt_r <= err_cnt_r + ERR_ONE;
                    end
                    if (err_cnt_r == ERR_ZERO) begin
                        fail_addr_r <= addr_s;
                        fail_exp_r  <= m_wdata_r;
                        fail_act_r  <= m.m_rdata;
                    end
                end
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign fail_addr = fail_addr_r;
    assign fail_exp  = fail_exp_r;
    assign fail_act  = fail_act_r;
    assign err_cnt   = err_cnt_r;

    assign m.m_req   = m_req_r;
    assign m.m_we    = m_we_r;
    assign m.m_addr  = addr_s;
    assign m.m_wdata = m_wdata_r;

endmodule
